inst_fetch: RTL and testbench
=============================

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the PC value loaded on reset.
REQ-002 SHALL have parameter DEPTH, default 2, the number of entries in the fetch buffer; legal values are 2 or 4.
REQ-003 SHALL have port Clk, input, 1 bit: the only clock; all state updates on the rising edge.
REQ-004 SHALL have port Clrn, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port Addr, output, 32 bits: the current PC, driven to the instruction memory address.
REQ-006 SHALL have port Inst, input, 32 bits: the instruction word returned combinationally for Addr in the same cycle.
REQ-007 SHALL have port Redirect, input, 1 bit: a taken branch or jump from a later stage.
REQ-008 SHALL have port Redirect_Pc, input, 32 bits: the target address, valid when Redirect=1.
REQ-009 SHALL have port If_Valid, output, 1 bit: the buffer head holds a valid instruction.
REQ-010 SHALL have port If_Ready, input, 1 bit: decode accepts the head this cycle.
REQ-011 SHALL have port If_Inst, output, 32 bits: the head instruction word.
REQ-012 SHALL have port If_Pc4, output, 32 bits: the head instruction's PC+4.
REQ-013 SHALL have port Misalign, output, 1 bit: sticky misaligned-target flag; the port exists only when FETCH_MISALIGN_TRAP_EN is defined.

Function
REQ-014 Addr SHALL equal the PC register at all times.
REQ-015 Push SHALL occur when Redirect=0 and the buffer is not full, or when Redirect=0, the buffer is full and a pop occurs in the same cycle.
REQ-016 A push SHALL write {PC, Inst} to the tail, and PC SHALL become PC+4 (modulo 2^32, wraps from 32'hFFFF_FFFC to 0).
REQ-017 When no push occurs and Redirect=0, PC SHALL hold.
REQ-018 A pop SHALL occur when If_Valid=1 and If_Ready=1, and SHALL advance the head.
REQ-019 If_Valid SHALL be 1 exactly when the count is nonzero.
REQ-020 If_Inst and If_Pc4 SHALL come from the head entry, with If_Pc4 stored as PC+4 of that entry.
REQ-021 Latency SHALL be one cycle: an instruction fetched in cycle t SHALL appear at the head in cycle t+1 if the buffer was empty.
REQ-022 With If_Ready held at 1, throughput SHALL be one instruction per cycle.
REQ-023 Full buffer with no pop SHALL stall fetch: PC holds and there is no push.
REQ-024 Redirect=1 SHALL have priority over all other actions: count becomes 0, PC becomes Redirect_Pc, there is no push, and any pop that cycle is discarded.
REQ-025 If_Valid SHALL be 0 in the cycle after a redirect.
REQ-026 The count SHALL never exceed DEPTH or go below 0.
REQ-027 Head and tail pointers SHALL wrap modulo DEPTH.

Reset
REQ-028 While Clrn=0, PC SHALL be RESET_PC, the count and pointers SHALL be 0, If_Valid SHALL be 0, and Misalign SHALL be 0.
REQ-029 Buffer data SHALL need no reset, and If_Inst and If_Pc4 SHALL be don't-care while If_Valid=0.
REQ-030 Assertion of Clrn mid-stall or mid-redirect SHALL immediately discard all state.
REQ-031 Fetch SHALL begin in the first cycle after Clrn deasserts.

Configuration
REQ-032 With FETCH_MISALIGN_TRAP_EN defined, a redirect with Redirect_Pc[1:0]!=0 SHALL set Misalign=1.
REQ-033 With FETCH_MISALIGN_TRAP_EN defined, PC SHALL load the target unchanged and pushes SHALL be inhibited until the next aligned redirect or reset.
REQ-034 With FETCH_MISALIGN_TRAP_EN defined, an aligned redirect SHALL clear Misalign.
REQ-035 Without FETCH_MISALIGN_TRAP_EN, Redirect_Pc[1:0] SHALL be forced to 2'b00 on load and the Misalign port SHALL be absent.

Structure
REQ-036 RESET_PC default, the instruction width (32) and the fetch entry struct {pc4[31:0], inst[31:0]} SHALL live in the shared CPU package.
REQ-037 One sub-module, fetch_fifo (parameterised DEPTH and width, push/pop/flush, count), SHALL hold the buffer; inst_fetch SHALL own the PC and control.

Verification
REQ-038 Reset release, If_Ready=1, ROM at 0/4/8 = A/B/C -> If_Inst = A, B, C on cycles 1-3, with If_Pc4 = 4, 8, 12.
REQ-039 If_Ready=0 for 4 cycles after reset -> buffer fills to DEPTH=2, Addr holds at 8; If_Ready=1 -> drains A, B, then C without gaps.
REQ-040 Redirect=1, Redirect_Pc=32'h30 while full -> next cycle If_Valid=0, Addr=32'h30; the following cycle If_Inst=ROM[0x30], If_Pc4=32'h34.
REQ-041 Redirect and pop in the same cycle -> the pop is discarded, the count is 0, and no stale instruction is ever presented.
REQ-042 Clrn pulsed low mid-stream with a full buffer -> Addr=RESET_PC and If_Valid=0 asynchronously, and fetch restarts at 0.
REQ-043 (FETCH_MISALIGN_TRAP_EN) Redirect_Pc=32'h32 -> Misalign=1 with no pushes; then Redirect_Pc=32'h40 -> Misalign=0 and fetch resumes at 32'h40.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// Shared CPU package: instruction width, reset PC default and the fetch buffer entry layout.
package inst_fetch_pkg;

    localparam int INST_W = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [INST_W-1:0] pc4;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

    // Sequential fetch address; wraps naturally at 2^32.
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small fetch buffer: DEPTH entries, combinational head read, push/pop/flush.
// Pointers wrap modulo DEPTH. Entry storage carries no reset.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0] head_reg, head_next;
    logic [PTR_W-1:0] tail_reg, tail_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             push_ok;
    logic             pop_ok;

    // Guard locally so the buffer can never over- or underflow.
    assign pop_ok  = pop && (count_reg != '0);
    assign push_ok = push && ((count_reg != CNT_W'(DEPTH)) || pop_ok);

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        head_next  = head_reg;
        tail_next  = tail_reg;
        count_next = count_reg;
        if (flush) begin
            head_next  = '0;
            tail_next  = '0;
            count_next = '0;
        end else begin
            if (pop_ok)
                head_next = ptr_inc(head_reg);
            if (push_ok)
                tail_next = ptr_inc(tail_reg);
            if (push_ok && !pop_ok)
                count_next = count_reg + 1'b1;
            else if (pop_ok && !push_ok)
                count_next = count_reg - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !flush)
            mem_reg[tail_reg] <= wdata;
    end

    assign rdata = mem_reg[head_reg];
    assign count = count_reg;
    assign full  = (count_reg == CNT_W'(DEPTH));

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: owns the PC, fetches one word per cycle into fetch_fifo, redirect flushes.
// Optional misaligned-target trap enabled by defining FETCH_MISALIGN_TRAP_EN.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          DEPTH    = 2
) (
    input  logic        Clk,
    input  logic        Clrn,
    output logic [31:0] Addr,
    input  logic [31:0] Inst,
    input  logic        Redirect,
    input  logic [31:0] Redirect_Pc,
    output logic        If_Valid,
    input  logic        If_Ready,
    output logic [31:0] If_Inst,
    output logic [31:0] If_Pc4
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic        Misalign
`endif
);

    logic [31:0]                pc_reg, pc_next;
    logic [31:0]                target_pc;
    logic                       fetch_block;
    logic                       push;
    logic                       pop;
    logic                       fifo_full;
    logic [$clog2(DEPTH+1)-1:0] fifo_count;
    fetch_entry_t               wr_entry;
    fetch_entry_t               rd_entry;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic misalign_reg;

    // A misaligned target is loaded as-is; fetch stays parked until an aligned redirect.
    assign target_pc   = Redirect_Pc;
    assign fetch_block = misalign_reg;
    assign Misalign    = misalign_reg;

    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn)
            misalign_reg <= 1'b0;
        else if (Redirect)
            misalign_reg <= |Redirect_Pc[1:0];
    end
`else
    assign target_pc   = Redirect_Pc & 32'hFFFF_FFFC;
    assign fetch_block = 1'b0;
`endif

    // Redirect discards any pop in its cycle; a full buffer accepts a push only alongside a pop.
    assign pop  = (fifo_count != '0) && If_Ready && !Redirect;
    assign push = !Redirect && !fetch_block && (!fifo_full || pop);

    always_comb begin
        pc_next = pc_reg;
        if (Redirect)
            pc_next = target_pc;
        else if (push)
            pc_next = pc_plus4(pc_reg);
    end

    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn)
            pc_reg <= RESET_PC;
        else
            pc_reg <= pc_next;
    end

    assign wr_entry.pc4  = pc_plus4(pc_reg);
    assign wr_entry.inst = Inst;

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (Clk),
        .rst_n (Clrn),
        .push  (push),
        .pop   (pop),
        .flush (Redirect),
        .wdata (wr_entry),
        .rdata (rd_entry),
        .count (fifo_count),
        .full  (fifo_full)
    );

    assign Addr     = pc_reg;
    assign If_Valid = (fifo_count != '0);
    assign If_Inst  = rd_entry.inst;
    assign If_Pc4   = rd_entry.pc4;

endmodule

// File: tb/tb_inst_fetch.sv
// Randomised bench for inst_fetch against a queue-based fetch model, plus directed scenarios.
// Honours FETCH_MISALIGN_TRAP_EN when defined.
module tb_inst_fetch;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        Clk = 1'b0;
    logic        Clrn = 1'b0;
    logic [31:0] Addr;
    logic [31:0] Inst;
    logic        Redirect = 1'b0;
    logic [31:0] Redirect_Pc = 32'h0;
    logic        If_Valid;
    logic        If_Ready = 1'b0;
    logic [31:0] If_Inst;
    logic [31:0] If_Pc4;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        Misalign;
`endif

    int checks = 0;
    int failures = 0;

    inst_fetch #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .Clk         (Clk),
        .Clrn        (Clrn),
        .Addr        (Addr),
        .Inst        (Inst),
        .Redirect    (Redirect),
        .Redirect_Pc (Redirect_Pc),
        .If_Valid    (If_Valid),
        .If_Ready    (If_Ready),
        .If_Inst     (If_Inst),
        .If_Pc4      (If_Pc4)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .Misalign    (Misalign)
`endif
    );

    always #5 Clk = ~Clk;

    // Instruction ROM: a scrambled function of the address, distinct per word.
    function automatic logic [31:0] rom(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000 ^ {a[15:0], a[31:16]};
    endfunction

    assign Inst = rom(Addr);

    // Reference model: a queue of in-flight instructions and a fetch address.
    typedef struct {
        logic [31:0] pc4;
        logic [31:0] inst;
    } ent_t;

    ent_t        q[$];
    logic [31:0] m_pc = RESET_PC;
    bit          m_mis = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic check_outputs();
        check_val("addr", Addr, m_pc);
        check_val("if_valid", {31'b0, If_Valid}, {31'b0, q.size() != 0});
        if (q.size() != 0) begin
            check_val("if_inst", If_Inst, q[0].inst);
            check_val("if_pc4", If_Pc4, q[0].pc4);
        end
`ifdef FETCH_MISALIGN_TRAP_EN
        check_val("misalign", {31'b0, Misalign}, {31'b0, m_mis});
`endif
    endtask

    task automatic model_edge(input bit rd, input logic [31:0] rpc, input bit rdy);
        bit popped;
        if (rd) begin
            q.delete();
`ifdef FETCH_MISALIGN_TRAP_EN
            m_mis = (rpc[1:0] != 2'b00);
            m_pc  = rpc;
`else
            m_pc  = rpc & 32'hFFFF_FFFC;
`endif
            $display("redirect target=%08h", rpc);
        end else begin
            popped = (q.size() > 0) && rdy;
            if (popped) begin
                $display("pop pc4=%08h inst=%08h", q[0].pc4, q[0].inst);
                void'(q.pop_front());
            end
            if (q.size() < DEPTH && !m_mis) begin
                q.push_back('{pc4: m_pc + 32'd4, inst: rom(m_pc)});
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic cycle(input bit rd, input logic [31:0] rpc, input bit rdy);
        Redirect    = rd;
        Redirect_Pc = rpc;
        If_Ready    = rdy;
        @(posedge Clk);
        model_edge(rd, rpc, rdy);
        #1;
        check_outputs();
    endtask

    // Asynchronous reset pulse mid-cycle; checks the immediate effect before any clock edge.
    task automatic do_reset();
        #2;
        Clrn = 1'b0;
        #1;
        check_val("rst_addr", Addr, RESET_PC);
        check_val("rst_valid", {31'b0, If_Valid}, 32'd0);
`ifdef FETCH_MISALIGN_TRAP_EN
        check_val("rst_misalign", {31'b0, Misalign}, 32'd0);
`endif
        Redirect = 1'b0;
        If_Ready = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        Clrn = 1'b1;
        q.delete();
        m_pc  = RESET_PC;
        m_mis = 1'b0;
        #1;
        check_outputs();
        $display("reset released");
    endtask

    initial begin
        logic [31:0] r;
        bit          rd;

        // Power-on reset
        @(negedge Clk);
        check_val("por_addr", Addr, RESET_PC);
        check_val("por_valid", {31'b0, If_Valid}, 32'd0);
        @(negedge Clk);
        Clrn = 1'b1;
        #1;
        check_outputs();

        // Streaming with If_Ready=1: A, B, C on consecutive cycles
        cycle(0, 32'h0, 1);
        check_val("s_inst0", If_Inst, rom(32'h0));
        check_val("s_pc4_0", If_Pc4, 32'h4);
        cycle(0, 32'h0, 1);
        check_val("s_inst1", If_Inst, rom(32'h4));
        check_val("s_pc4_1", If_Pc4, 32'h8);
        cycle(0, 32'h0, 1);
        check_val("s_inst2", If_Inst, rom(32'h8));
        check_val("s_pc4_2", If_Pc4, 32'hC);

        // Stall until full, then drain without gaps
        do_reset();
        for (int i = 0; i < 4; i++)
            cycle(0, 32'h0, 0);
        check_val("stall_addr", Addr, 32'h8);
        check_val("stall_head", If_Inst, rom(32'h0));
        cycle(0, 32'h0, 1);
        check_val("drain_b", If_Inst, rom(32'h4));
        cycle(0, 32'h0, 1);
        check_val("drain_c", If_Inst, rom(32'h8));
        check_val("drain_c_pc4", If_Pc4, 32'hC);

        // Redirect while full
        cycle(0, 32'h0, 0);
        cycle(0, 32'h0, 0);
        cycle(1, 32'h30, 0);
        check_val("redir_valid", {31'b0, If_Valid}, 32'd0);
        check_val("redir_addr", Addr, 32'h30);
        cycle(0, 32'h0, 0);
        check_val("redir_inst", If_Inst, rom(32'h30));
        check_val("redir_pc4", If_Pc4, 32'h34);

        // Redirect coinciding with a pop
        cycle(0, 32'h0, 0);
        cycle(1, 32'h100, 1);
        check_val("rp_valid", {31'b0, If_Valid}, 32'd0);
        cycle(0, 32'h0, 1);
        check_val("rp_inst", If_Inst, rom(32'h100));

        // Reset mid-stream with a full buffer, restart at RESET_PC
        cycle(0, 32'h0, 0);
        cycle(0, 32'h0, 0);
        do_reset();
        cycle(0, 32'h0, 1);
        check_val("restart_pc4", If_Pc4, RESET_PC + 32'd4);

`ifdef FETCH_MISALIGN_TRAP_EN
        // Misaligned redirect parks fetch; aligned redirect resumes it
        cycle(1, 32'h32, 1);
        check_val("mis_set", {31'b0, Misalign}, 32'd1);
        check_val("mis_addr", Addr, 32'h32);
        cycle(0, 32'h0, 1);
        cycle(0, 32'h0, 1);
        check_val("mis_nopush", {31'b0, If_Valid}, 32'd0);
        check_val("mis_hold", Addr, 32'h32);
        cycle(1, 32'h40, 1);
        check_val("mis_clr", {31'b0, Misalign}, 32'd0);
        cycle(0, 32'h0, 1);
        check_val("mis_resume", If_Pc4, 32'h44);
`endif

        // Randomised traffic, including PC wrap targets and occasional resets
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
            end else begin
                rd = ($urandom_range(0, 15) == 0);
                r  = $urandom;
                if ($urandom_range(0, 3) == 0)
                    r = 32'hFFFF_FFF0 | (r & 32'hF);
                if ($urandom_range(0, 7) != 0)
                    r = r & 32'hFFFF_FFFC;
                cycle(rd, r, $urandom_range(0, 3) != 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
